// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// presents it to instruction memory, and latches the returned word into the
// IF/ID pipeline register. Handles stall, flush, branch/jump redirection and
// a halt state entered when the sentinel HALT_WORD is fetched. Also counts
// the instructions delivered downstream.
//
// Parameters
//   RESET_PC          PC value loaded on reset
//   HALT_WORD         instruction encoding that stops fetch
// Ports
//   clk               rising-edge clock shared with instruction memory
//   reset             synchronous, active-high; overrides every other input
//   stall             hold PC and IF/ID
//   flush             squash IF/ID at the next edge
//   branchTaken       redirect PC to branchTarget
//   branchTarget      branch target byte address
//   jump              redirect PC to jumpTarget (wins over branchTaken)
//   jumpTarget        jump target byte address
//   instruction       instruction-memory read data for readAddress
//   readAddress       current PC (byte address), straight from the PC register
//   ifid_instruction  latched instruction, 0 (NOP) when invalid
//   ifid_pcPlus4      PC+4 of the latched instruction
//   ifid_valid        IF/ID holds a real instruction
//   halted            fetch is in the HALTED state
//   addrMisaligned    one-cycle pulse: last redirect target had bits [1:0] != 0
//   fetchCount        number of instructions latched with ifid_valid=1
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] instruction,
  output logic [31:0] readAddress,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pcPlus4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        addrMisaligned,
  output logic [31:0] fetchCount
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q, count_d;

  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Jump outranks branch when both redirect in the same cycle.
  assign redirect_s = jump | branchTaken;
  assign target_s   = jump ? jumpTarget : branchTarget;
  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 silently.
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state logic: FSM transition plus PC / IF/ID / counter updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    misaligned_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (redirect_s) begin
          // The word being fetched this cycle is wrong-path, so IF/ID empties.
          pc_d         = {target_s[31:2], 2'b00};
          ifid_instr_d = 32'h0000_0000;
          ifid_pc4_d   = 32'h0000_0000;
          ifid_valid_d = 1'b0;
          misaligned_d = |target_s[1:0];
        end else if (stall) begin
          if (flush) begin
            ifid_instr_d = 32'h0000_0000;
            ifid_pc4_d   = 32'h0000_0000;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_valid_d = ifid_valid_q;
          end
        end else if (flush) begin
          pc_d         = pc_plus4_s;
          ifid_instr_d = 32'h0000_0000;
          ifid_pc4_d   = 32'h0000_0000;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_instr_d = instruction;
          ifid_pc4_d   = pc_plus4_s;
          ifid_valid_d = 1'b1;
          count_d      = count_q + 32'd1;
          // The halt word itself is delivered; the PC then parks on it.
          if (instruction == HALT_WORD) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end
      ST_HALTED: begin
        ifid_instr_d = 32'h0000_0000;
        ifid_pc4_d   = 32'h0000_0000;
        ifid_valid_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: recover to a clean reset-like state.
        state_d      = ST_RUN;
        pc_d         = RESET_PC;
        ifid_instr_d = 32'h0000_0000;
        ifid_pc4_d   = 32'h0000_0000;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign readAddress      = pc_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_pcPlus4     = ifid_pc4_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = (state_q == ST_HALTED);
  assign addrMisaligned   = misaligned_q;
  assign fetchCount       = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model of the fetch stage
// (PC, IF/ID contents, halt flag, misalignment pulse, delivered count) is
// advanced once per clock edge from the same inputs the DUT sees; all DUT
// outputs are compared to it on every falling edge. Directed scenarios pin
// the model with hand-computed literals, then a randomized phase runs.
// A second instance with RESET_PC = 32'hFFFF_FFF8 exercises PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = 32'h0;
  logic [31:0] instruction;
  logic [31:0] readAddress, ifid_instruction, ifid_pcPlus4, fetchCount;
  logic        ifid_valid, halted, addrMisaligned;

  // Wrap-around instance signals (free-running, no control inputs).
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic [31:0] w_instr, w_addr, w_ins, w_pc4, w_cnt;
  logic        w_valid, w_halted, w_mis;

  // Address at which memory returns the halt word (1 = never, unaligned).
  logic [31:0] halt_addr = 32'h0000_0001;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic [31:0] m_pc = 32'h0, m_ins = 32'h0, m_pc4 = 32'h0, m_cnt = 32'h0;
  logic        m_valid = 1'b0, m_halted = 1'b0, m_mis = 1'b0;

  always #5 clk = ~clk;

  assign instruction = (readAddress == halt_addr) ? HALT : (readAddress ^ XORK);
  assign w_instr     = w_addr ^ XORK;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .instruction(instruction),
    .readAddress(readAddress), .ifid_instruction(ifid_instruction),
    .ifid_pcPlus4(ifid_pcPlus4), .ifid_valid(ifid_valid), .halted(halted),
    .addrMisaligned(addrMisaligned), .fetchCount(fetchCount)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .stall(w_zero), .flush(w_zero),
    .branchTaken(w_zero), .branchTarget(w_zero32),
    .jump(w_zero), .jumpTarget(w_zero32), .instruction(w_instr),
    .readAddress(w_addr), .ifid_instruction(w_ins),
    .ifid_pcPlus4(w_pc4), .ifid_valid(w_valid), .halted(w_halted),
    .addrMisaligned(w_mis), .fetchCount(w_cnt)
  );

  // Instruction memory contents as seen by the model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? HALT : (a ^ XORK);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock edge of the fetch stage, from the rules in priority order.
  task automatic model_edge();
    logic [31:0] tgt;
    logic [31:0] w;
    if (reset) begin
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_cnt = 32'h0; m_mis = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (jump || branchTaken) begin
      tgt = jump ? jumpTarget : branchTarget;
      m_pc = tgt & 32'hFFFF_FFFC;
      m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_mis = (tgt % 32'd4) != 32'd0;
    end else if (stall) begin
      m_mis = 1'b0;
      if (flush) begin
        m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end
    end else if (flush) begin
      m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
      m_pc = m_pc + 32'd4;
    end else begin
      w = mem_word(m_pc);
      m_ins = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_mis = 1'b0;
      m_cnt = m_cnt + 32'd1;
      if (w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    check("readAddress", readAddress, m_pc);
    check("ifid_instruction", ifid_instruction, m_ins);
    check("ifid_pcPlus4", ifid_pcPlus4, m_pc4);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("addrMisaligned", {31'd0, addrMisaligned}, {31'd0, m_mis});
    check("fetchCount", fetchCount, m_cnt);
  endtask

  // Drive inputs away from the edge, advance the model at the edge,
  // compare on the falling edge.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    reset = rst; stall = st; flush = fl;
    branchTaken = br; branchTarget = bt; jump = jp; jumpTarget = jt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run1();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_addr", readAddress, 32'h0000_0000);
    check("rst_cnt", fetchCount, 32'h0000_0000);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);

    // Free run
    run1();
    check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    run1();
    check("wrap_addr2", w_addr, 32'h0000_0000);
    check("wrap_pc4", w_pc4, 32'h0000_0000);
    check("wrap_ins", w_ins, 32'h5A5A_FFFC);
    check("wrap_misc", {29'd0, w_valid, w_halted, w_mis}, 32'h0000_0004);
    check("wrap_cnt", w_cnt, 32'h0000_0002);
    run1();
    check("free_addr", readAddress, 32'h0000_000C);
    check("free_ins", ifid_instruction, 32'hA5A5_0008);
    check("free_pc4", ifid_pcPlus4, 32'h0000_000C);
    check("free_cnt", m_cnt, 32'h0000_0003);
    run1();

    // Stall 3 cycles at PC=0x10
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_addr", readAddress, 32'h0000_0010);
    check("stall_ins", ifid_instruction, 32'hA5A5_000C);
    check("stall_cnt", fetchCount, 32'h0000_0004);
    run1();
    check("unstall_addr", m_pc, 32'h0000_0014);
    check("unstall_cnt", fetchCount, 32'h0000_0005);

    // Redirect collisions
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    check("br_stall_addr", readAddress, 32'h0000_0040);
    check("br_stall_valid", {31'd0, ifid_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
    check("jmp_prio_addr", m_pc, 32'h0000_0080);

    // Misaligned target
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0045, 1'b0, 32'h0);
    check("mis_addr", readAddress, 32'h0000_0044);
    check("mis_pulse", {31'd0, addrMisaligned}, 32'h1);
    run1();
    check("mis_clear", {31'd0, addrMisaligned}, 32'h0);
    check("mis_next_ins", ifid_instruction, 32'hA5A5_0044);

    // Halt at 0x20
    halt_addr = 32'h0000_0020;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
    run1();
    check("halt_ins", ifid_instruction, 32'hFFFF_FFFF);
    check("halt_valid", {31'd0, ifid_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
    check("halt_hold_addr", readAddress, 32'h0000_0020);
    check("halt_flag", {31'd0, halted}, 32'h1);
    check("halt_bubble", {31'd0, m_valid}, 32'h0);
    halt_addr = 32'h0000_0001;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("halt_reset_addr", readAddress, 32'h0000_0000);
    check("halt_reset_flag", {31'd0, halted}, 32'h0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_st, r_fl, r_br, r_jp;
      logic [31:0] r_bt, r_jt;
      r_rst = ($urandom_range(0, 63) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 5) == 0);
      r_br  = ($urandom_range(0, 7) == 0);
      r_jp  = ($urandom_range(0, 9) == 0);
      r_bt  = ($urandom_range(0, 1) == 0) ? $urandom() : {24'd0, 8'($urandom_range(0, 255))};
      r_jt  = ($urandom_range(0, 1) == 0) ? $urandom() : {24'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 39) == 0) halt_addr = m_pc;
      else if ($urandom_range(0, 39) == 0) halt_addr = 32'h0000_0001;
      step(r_rst, r_st, r_fl, r_br, r_bt, r_jp, r_jt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
